ahb_burst_master: RTL

// - Synthesizable AHB-Lite/AHB2 master stage that sits upstream of ahb_slv_responder in the tb.
// - Accepts one burst command at a time and requests the bus. Once granted, it drives a

---
 rtl/ahb_pkg.sv | 50 +++++
 rtl/ahb_addr_gen.sv | 35 +++
 rtl/ahb_burst_master.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite transfer, burst, response and size encodings shared by the burst master.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01,
        HR_RETRY = 2'b10,
        HR_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HSIZE_8  = 3'd0;
    localparam logic [2:0] HSIZE_16 = 3'd1;
    localparam logic [2:0] HSIZE_32 = 3'd2;
    localparam logic [2:0] HSIZE_64 = 3'd3;

    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    function automatic logic [4:0] beats_of(input logic [2:0] burst);
        case (burst)
            HB_WRAP4,  HB_INCR4:  beats_of = 5'd4;
            HB_WRAP8,  HB_INCR8:  beats_of = 5'd8;
            HB_WRAP16, HB_INCR16: beats_of = 5'd16;
            default:              beats_of = 5'd1;
        endcase
    endfunction

    function automatic logic is_wrap(input logic [2:0] burst);
        return (burst == HB_WRAP4) || (burst == HB_WRAP8) || (burst == HB_WRAP16);
    endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Next-beat address for a burst: linear increment, or wrap inside the
// window of beats*transfer-size bytes with the upper address bits held.
module ahb_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        case (hsize)
            HSIZE_8:  step = ADDR_W'(1);
            HSIZE_16: step = ADDR_W'(2);
            HSIZE_32: step = ADDR_W'(4);
            HSIZE_64: step = ADDR_W'(8);
            default:  step = ADDR_W'(8);
        endcase
        incr      = addr + step;
        wrap_mask = (ADDR_W'(beats_of(hburst)) << hsize) - ADDR_W'(1);
        if (is_wrap(hburst)) begin
            next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
        end else begin
            next_addr = incr;
        end
    end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: takes one command at a time, arbitrates for the bus and
// drives a pipelined address/data burst with write backpressure and error abort.
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter bit KEEP_REQ = 1'b0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [2:0]        cmd_burst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              done_valid,
    output logic              done_err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    output logic              hbusreq,
    output logic              hlock,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic [1:0]        hresp,
    input  logic              hgrant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_BURST,
        S_LAST_DATA,
        S_ERR
    } state_e;

    state_e            state;
    logic [1:0]        htrans_q;
    logic [2:0]        burst_q;
    logic [4:0]        beats_left;
    logic              dp_valid;
    logic              dp_last;
    logic [ADDR_W-1:0] next_addr;
    logic              addr_accept;
    logic              err_wait;

    // burst_q keeps the original burst type so wrapping survives a re-arbitration
    ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (haddr),
        .hsize     (hsize),
        .hburst    (burst_q),
        .next_addr (next_addr)
    );

    assign addr_accept = htrans_q[1] && (!hwrite || wr_valid) && hready;
    assign err_wait    = dp_valid && !hready && (hresp != HR_OKAY);
    assign wr_ready    = hwrite && addr_accept;
    assign hlock       = 1'b0;

    // First error cycle cancels the pending address; a missing write beat stalls with BUSY
    always_comb begin
        htrans = htrans_q;
        if (err_wait) begin
            htrans = HT_IDLE;
        end else if (htrans_q[1] && hwrite && !wr_valid) begin
            htrans = (htrans_q == NONSEQ) ? HT_IDLE : HT_BUSY;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b0;
            hbusreq    <= 1'b0;
            htrans_q   <= HT_IDLE;
            haddr      <= '0;
            hwrite     <= 1'b0;
            hsize      <= 3'd0;
            hburst     <= 3'd0;
            burst_q    <= 3'd0;
            hwdata     <= '0;
            beats_left <= 5'd0;
            dp_valid   <= 1'b0;
            dp_last    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_data    <= '0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    hbusreq   <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_burst == HB_INCR) begin
                            done_valid <= 1'b1;
                            done_err   <= 1'b1;
                        end else begin
                            cmd_ready  <= 1'b0;
                            hbusreq    <= 1'b1;
                            haddr      <= cmd_addr;
                            hwrite     <= cmd_write;
                            hsize      <= cmd_size;
                            hburst     <= cmd_burst;
                            burst_q    <= cmd_burst;
                            beats_left <= beats_of(cmd_burst);
                            state      <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    if (hready) begin
                        done_valid <= 1'b1;
                        done_err   <= 1'b1;
                        dp_valid   <= 1'b0;
                        hbusreq    <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    if (dp_valid && (hresp != HR_OKAY)) begin
                        htrans_q <= HT_IDLE;
                        if (hready) begin
                            done_valid <= 1'b1;
                            done_err   <= 1'b1;
                            dp_valid   <= 1'b0;
                            hbusreq    <= 1'b0;
                            cmd_ready  <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_ERR;
                        end
                    end else if (hready) begin
                        if (dp_valid && !hwrite) begin
                            rd_valid <= 1'b1;
                            rd_data  <= hrdata;
                            rd_last  <= dp_last;
                        end
                        if (addr_accept && hwrite) begin
                            hwdata <= wr_data;
                        end
                        dp_valid <= addr_accept;
                        dp_last  <= addr_accept && (beats_left == 5'd1);
                        if (dp_valid && dp_last) begin
                            done_valid <= 1'b1;
                            cmd_ready  <= 1'b1;
                            hbusreq    <= KEEP_REQ && cmd_valid;
                            state      <= S_IDLE;
                        end else if (state == S_REQ) begin
                            if (hgrant) begin
                                htrans_q <= NONSEQ;
                                state    <= S_ADDR;
                            end
                        end else if (addr_accept && (beats_left == 5'd1)) begin
                            htrans_q <= HT_IDLE;
                            hbusreq  <= KEEP_REQ && cmd_valid;
                            state    <= S_LAST_DATA;
                        end else if (state != S_LAST_DATA) begin
                            if (addr_accept) begin
                                haddr      <= next_addr;
                                beats_left <= beats_left - 5'd1;
                            end
                            // Lost grant: resume later as an undefined-length INCR from the next address
                            if (!hgrant) begin
                                htrans_q <= HT_IDLE;
                                hburst   <= HB_INCR;
                                state    <= S_REQ;
                            end else if (addr_accept) begin
                                htrans_q <= SEQ;
                                state    <= S_BURST;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
